// File: rtl/io_frontend_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared types for the CPU I/O front end: control FSM states, display-mode
// encodings and the display-mode advance function.
// -----------------------------------------------------------------------------
package cpu_io_pkg;

   typedef enum logic [1:0] {
      HALT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } cpu_state_e;

   typedef enum logic [1:0] {
      DISP_PC     = 2'd0,
      DISP_REG1   = 2'd1,
      DISP_CYCLES = 2'd2
   } disp_mode_e;

   // Cycles PC -> REG1 -> CYCLES -> PC; the unused code 3 recovers to PC.
   function automatic logic [1:0] next_disp_mode(input logic [1:0] mode);
      logic [1:0] nxt;
      case (mode)
         DISP_PC:   nxt = DISP_REG1;
         DISP_REG1: nxt = DISP_CYCLES;
         default:   nxt = DISP_PC;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/io_frontend_if.sv
// -----------------------------------------------------------------------------
// io_frontend_if
// Bundle between the board/CPU side and the I/O front end.
//   switchRaw      : raw asynchronous switches (board -> front end)
//   pc             : CPU program counter        (CPU -> front end)
//   register1Value : CPU register 1             (CPU -> front end)
//   switchLevel    : debounced switch levels    (front end -> CPU/board)
//   switchPressed  : one-cycle rising pulses    (front end -> CPU/board)
//   cpuEnable      : CPU clock enable           (front end -> CPU)
//   displayMode    : current display selection  (front end -> board)
//   outputValue    : registered display value   (front end -> board)
// master = board/CPU side, slave = io_frontend.
// -----------------------------------------------------------------------------
interface io_frontend_if #(
   parameter int NUM_SWITCHES   = 3,
   parameter int REGISTER_WIDTH = 8,
   parameter int PC_WIDTH       = 4
);
   logic [NUM_SWITCHES-1:0]   switchRaw;
   logic [PC_WIDTH-1:0]       pc;
   logic [REGISTER_WIDTH-1:0] register1Value;
   logic [NUM_SWITCHES-1:0]   switchLevel;
   logic [NUM_SWITCHES-1:0]   switchPressed;
   logic                      cpuEnable;
   logic [1:0]                displayMode;
   logic [REGISTER_WIDTH-1:0] outputValue;

   modport master (
      output switchRaw, pc, register1Value,
      input  switchLevel, switchPressed, cpuEnable, displayMode, outputValue
   );

   modport slave (
      input  switchRaw, pc, register1Value,
      output switchLevel, switchPressed, cpuEnable, displayMode, outputValue
   );
endinterface

// File: rtl/io_frontend_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// One switch channel: 2-flop synchroniser, stability counter and rising-edge
// pulse generator.
//   clock     : rising-edge clock
//   isReset   : synchronous active-high reset
//   raw_i     : asynchronous raw switch input
//   level_o   : debounced level
//   pressed_o : one-cycle pulse in the cycle level_o rises
// -----------------------------------------------------------------------------
module switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic isReset,
   input  logic raw_i,
   output logic level_o,
   output logic pressed_o
);
   import cpu_io_pkg::*;

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             pressed_q, pressed_d;

   // The level is taken on the edge that would bring the count to
   // DEBOUNCE_CYCLES, so the pulse is registered alongside the new level.
   always_comb begin
      cnt_d     = '0;
      level_d   = level_q;
      pressed_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d   = sync2_q;
            pressed_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (isReset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         pressed_q <= 1'b0;
      end else begin
         sync1_q   <= raw_i;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         pressed_q <= pressed_d;
      end
   end

   assign level_o   = level_q;
   assign pressed_o = pressed_q;

endmodule

// File: rtl/io_frontend.sv
// -----------------------------------------------------------------------------
// io_frontend
// Front panel for a small CPU: debounces the switches, runs the HALT/RUN/STEP
// control FSM that gates the CPU clock enable, counts enabled cycles and
// drives a registered display mux.
//   clock   : rising-edge clock
//   isReset : synchronous active-high reset
//   bus     : io_frontend_if.slave (switches, pc, register1Value in;
//             switchLevel, switchPressed, cpuEnable, displayMode,
//             outputValue out)
// switchRaw bit0 = run/halt, bit1 = step, bit2 = display select.
// -----------------------------------------------------------------------------
module io_frontend #(
   parameter int NUM_SWITCHES    = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REGISTER_WIDTH  = 8,
   parameter int PC_WIDTH        = 4
) (
   input logic          clock,
   input logic          isReset,
   io_frontend_if.slave bus
);
   import cpu_io_pkg::*;

   logic [NUM_SWITCHES-1:0] level;
   logic [NUM_SWITCHES-1:0] pressed;

   for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_sw
      switch_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock    (clock),
         .isReset  (isReset),
         .raw_i    (bus.switchRaw[g]),
         .level_o  (level[g]),
         .pressed_o(pressed[g])
      );
   end

   cpu_state_e                state_q, state_d;
   logic [REGISTER_WIDTH-2:0] cyc_q, cyc_d;
   logic [1:0]                mode_q, mode_d;
   logic [REGISTER_WIDTH-1:0] out_q, out_d;
   logic                      cpu_en;

   // Run/halt has priority over step; STEP is a single enabled cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HALT: begin
            if (pressed[0])      state_d = RUN;
            else if (pressed[1]) state_d = STEP;
         end
         RUN: begin
            if (pressed[0]) state_d = HALT;
         end
         STEP:    state_d = HALT;
         default: state_d = HALT;
      endcase
   end

   assign cpu_en = (state_q == RUN) || (state_q == STEP);

   always_comb begin
      cyc_d = cpu_en ? cyc_q + 1'b1 : cyc_q;
   end

   always_comb begin
      mode_d = pressed[2] ? next_disp_mode(mode_q) : mode_q;
   end

   // Selected by the next mode so the display follows a select press with
   // only the register's one cycle of delay.
   always_comb begin
      out_d = '0;
      case (mode_d)
         DISP_PC:     out_d = REGISTER_WIDTH'(bus.pc);
         DISP_REG1:   out_d = bus.register1Value;
         DISP_CYCLES: out_d = {state_q == HALT, cyc_q};
         default:     out_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (isReset) begin
         state_q <= HALT;
         cyc_q   <= '0;
         mode_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         mode_q  <= mode_d;
         out_q   <= out_d;
      end
   end

   assign bus.switchLevel   = level;
   assign bus.switchPressed = pressed;
   assign bus.cpuEnable     = cpu_en;
   assign bus.displayMode   = mode_q;
   assign bus.outputValue   = out_q;

endmodule

// File: tb/tb_io_frontend.sv
// -----------------------------------------------------------------------------
// tb_io_frontend
// Scoreboard bench for io_frontend with DEBOUNCE_CYCLES=4, REGISTER_WIDTH=8,
// PC_WIDTH=4. Cycle N is the interval after the N-th rising clock edge;
// stimulus changes 1 time unit after an edge, outputs are sampled on the
// falling edge. A raw change made in cycle c shows on switchLevel in cycle c+6.
// -----------------------------------------------------------------------------
module tb_io_frontend;

   logic clock = 1'b0;
   logic isReset = 1'b1;
   int   cyc = 0;
   bit   done = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   io_frontend_if #(.NUM_SWITCHES(3), .REGISTER_WIDTH(8), .PC_WIDTH(4)) bus ();

   io_frontend #(
      .NUM_SWITCHES   (3),
      .DEBOUNCE_CYCLES(4),
      .REGISTER_WIDTH (8),
      .PC_WIDTH       (4)
   ) dut (
      .clock  (clock),
      .isReset(isReset),
      .bus    (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [2:0] lvl;
      logic       en;
      logic [1:0] mode;
      logic [7:0] outv;
   } ck_t;

   typedef struct {
      int         cyc;
      logic [2:0] bits;
   } pl_t;

   ck_t ck_q[$];
   pl_t pl_q[$];
   ck_t ce;
   pl_t pe;

   task automatic ck(input int c, input logic [2:0] l, input logic e,
                     input logic [1:0] m, input logic [7:0] o);
      ck_t t;
      t.cyc = c; t.lvl = l; t.en = e; t.mode = m; t.outv = o;
      ck_q.push_back(t);
   endtask

   task automatic pls(input int c, input logic [2:0] b);
      pl_t t;
      t.cyc = c; t.bits = b;
      pl_q.push_back(t);
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clock) begin
      while (ck_q.size() > 0 && ck_q[0].cyc <= cyc) begin
         ce = ck_q.pop_front();
         n_cmp++;
         if (ce.cyc != cyc || bus.switchLevel !== ce.lvl || bus.cpuEnable !== ce.en ||
             bus.displayMode !== ce.mode || bus.outputValue !== ce.outv) begin
            n_fail++;
            $display("FAIL state@%0d (cycle %0d): got lvl=%b en=%b mode=%0d out=%h, want lvl=%b en=%b mode=%0d out=%h",
                     ce.cyc, cyc, bus.switchLevel, bus.cpuEnable, bus.displayMode, bus.outputValue,
                     ce.lvl, ce.en, ce.mode, ce.outv);
         end
      end
      while (pl_q.size() > 0 && pl_q[0].cyc < cyc) begin
         pe = pl_q.pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL press@%0d: got no pulse, want switchPressed=%b", pe.cyc, pe.bits);
      end
      if (bus.switchPressed != 3'b000) begin
         n_cmp++;
         if (pl_q.size() > 0 && pl_q[0].cyc == cyc) begin
            pe = pl_q.pop_front();
            if (bus.switchPressed !== pe.bits) begin
               n_fail++;
               $display("FAIL press@%0d: got switchPressed=%b, want %b", cyc, bus.switchPressed, pe.bits);
            end
         end else begin
            n_fail++;
            $display("FAIL spurious_press@%0d: got switchPressed=%b, want 000", cyc, bus.switchPressed);
         end
      end
      if (done) begin
         while (ck_q.size() > 0) begin
            ce = ck_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL state@%0d: got never checked, want out=%h", ce.cyc, ce.outv);
         end
         while (pl_q.size() > 0) begin
            pe = pl_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL press@%0d: got never seen, want %b", pe.cyc, pe.bits);
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no end of stimulus, want finish before 100000");
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      bus.switchRaw      = 3'b000;
      bus.pc             = 4'h3;
      bus.register1Value = 8'h5C;
      ck(3, 3'b000, 1'b0, 2'd0, 8'h00);
      ck(4, 3'b000, 1'b0, 2'd0, 8'h03);
      goto(3);
      isReset = 1'b0;

      // bit0 press from HALT: level/pulse at +6, RUN one cycle later
      goto(10); bus.switchRaw[0] = 1'b1;
      ck(15, 3'b000, 1'b0, 2'd0, 8'h03);
      ck(16, 3'b001, 1'b0, 2'd0, 8'h03);
      pls(16, 3'b001);
      ck(17, 3'b001, 1'b1, 2'd0, 8'h03);
      goto(20); bus.switchRaw[0] = 1'b0;
      ck(26, 3'b000, 1'b1, 2'd0, 8'h03);
      goto(30); bus.switchRaw[0] = 1'b1;
      pls(36, 3'b001);
      ck(36, 3'b001, 1'b1, 2'd0, 8'h03);
      ck(37, 3'b001, 1'b0, 2'd0, 8'h03);
      goto(40); bus.switchRaw[0] = 1'b0;
      ck(46, 3'b000, 1'b0, 2'd0, 8'h03);

      // 3-cycle glitch on bit1: nothing happens
      goto(50); bus.switchRaw[1] = 1'b1;
      goto(53); bus.switchRaw[1] = 1'b0;
      ck(60, 3'b000, 1'b0, 2'd0, 8'h03);

      // reset clears the cycle counter
      goto(62); isReset = 1'b1;
      goto(64); isReset = 1'b0;
      ck(64, 3'b000, 1'b0, 2'd0, 8'h00);
      ck(65, 3'b000, 1'b0, 2'd0, 8'h03);

      // single step
      goto(70); bus.switchRaw[1] = 1'b1;
      ck(76, 3'b010, 1'b0, 2'd0, 8'h03);
      pls(76, 3'b010);
      ck(77, 3'b010, 1'b1, 2'd0, 8'h03);
      ck(78, 3'b010, 1'b0, 2'd0, 8'h03);
      goto(80); bus.switchRaw[1] = 1'b0;
      ck(86, 3'b000, 1'b0, 2'd0, 8'h03);

      // display select to REG1 then CYCLES (counter = 1, halted)
      goto(90); bus.switchRaw[2] = 1'b1;
      ck(96, 3'b100, 1'b0, 2'd0, 8'h03);
      pls(96, 3'b100);
      ck(97, 3'b100, 1'b0, 2'd1, 8'h5C);
      goto(100); bus.switchRaw[2] = 1'b0;
      goto(110); bus.switchRaw[2] = 1'b1;
      pls(116, 3'b100);
      ck(116, 3'b100, 1'b0, 2'd1, 8'h5C);
      ck(117, 3'b100, 1'b0, 2'd2, 8'h81);
      goto(120); bus.switchRaw[2] = 1'b0;
      ck(126, 3'b000, 1'b0, 2'd2, 8'h81);

      // simultaneous run+step: RUN wins; counter shows while running
      goto(130); bus.switchRaw[1:0] = 2'b11;
      pls(136, 3'b011);
      ck(136, 3'b011, 1'b0, 2'd2, 8'h81);
      ck(137, 3'b011, 1'b1, 2'd2, 8'h81);
      ck(138, 3'b011, 1'b1, 2'd2, 8'h01);
      ck(139, 3'b011, 1'b1, 2'd2, 8'h02);
      ck(140, 3'b011, 1'b1, 2'd2, 8'h03);
      goto(140); bus.switchRaw[1:0] = 2'b00;

      // step press while running is ignored
      goto(150); bus.switchRaw[1] = 1'b1;
      ck(150, 3'b000, 1'b1, 2'd2, 8'h0D);
      pls(156, 3'b010);
      ck(158, 3'b010, 1'b1, 2'd2, 8'h15);
      goto(160); bus.switchRaw[1] = 1'b0;

      // reset mid-RUN, then run exactly 130 cycles across the counter wrap
      goto(170); isReset = 1'b1;
      goto(172); isReset = 1'b0;
      ck(172, 3'b000, 1'b0, 2'd0, 8'h00);
      ck(173, 3'b000, 1'b0, 2'd0, 8'h03);
      goto(180); bus.switchRaw[0] = 1'b1;
      pls(186, 3'b001);
      ck(187, 3'b001, 1'b1, 2'd0, 8'h03);
      goto(190); bus.switchRaw[0] = 1'b0;
      goto(310); bus.switchRaw[0] = 1'b1;
      pls(316, 3'b001);
      ck(316, 3'b001, 1'b1, 2'd0, 8'h03);
      ck(317, 3'b001, 1'b0, 2'd0, 8'h03);
      goto(320); bus.switchRaw[0] = 1'b0;
      goto(330); bus.switchRaw[2] = 1'b1;
      pls(336, 3'b100);
      ck(337, 3'b100, 1'b0, 2'd1, 8'h5C);
      goto(340); bus.switchRaw[2] = 1'b0;
      goto(350); bus.switchRaw[2] = 1'b1;
      pls(356, 3'b100);
      ck(357, 3'b100, 1'b0, 2'd2, 8'h82);
      goto(360); bus.switchRaw[2] = 1'b0;

      // pc = A, full display cycle
      goto(365); bus.pc = 4'hA;
      goto(370); bus.switchRaw[2] = 1'b1;
      pls(376, 3'b100);
      ck(376, 3'b100, 1'b0, 2'd2, 8'h82);
      ck(377, 3'b100, 1'b0, 2'd0, 8'h0A);
      goto(380); bus.switchRaw[2] = 1'b0;
      goto(390); bus.switchRaw[2] = 1'b1;
      pls(396, 3'b100);
      ck(397, 3'b100, 1'b0, 2'd1, 8'h5C);
      goto(400); bus.switchRaw[2] = 1'b0;
      goto(410); bus.switchRaw[2] = 1'b1;
      pls(416, 3'b100);
      ck(417, 3'b100, 1'b0, 2'd2, 8'h82);
      goto(420); bus.switchRaw[2] = 1'b0;
      goto(430); bus.switchRaw[2] = 1'b1;
      pls(436, 3'b100);
      ck(437, 3'b100, 1'b0, 2'd0, 8'h0A);
      goto(440); bus.switchRaw[2] = 1'b0;

      // RUN, then reset with bit1 held through it: press appears 6 cycles
      // after release and produces one step
      goto(450); bus.switchRaw[0] = 1'b1;
      pls(456, 3'b001);
      ck(457, 3'b001, 1'b1, 2'd0, 8'h0A);
      ck(460, 3'b001, 1'b1, 2'd0, 8'h0A);
      goto(462);
      bus.switchRaw[0] = 1'b0;
      bus.switchRaw[1] = 1'b1;
      isReset = 1'b1;
      ck(463, 3'b000, 1'b0, 2'd0, 8'h00);
      goto(464); isReset = 1'b0;
      ck(464, 3'b000, 1'b0, 2'd0, 8'h00);
      ck(465, 3'b000, 1'b0, 2'd0, 8'h0A);
      pls(470, 3'b010);
      ck(470, 3'b010, 1'b0, 2'd0, 8'h0A);
      ck(471, 3'b010, 1'b1, 2'd0, 8'h0A);
      ck(472, 3'b010, 1'b0, 2'd0, 8'h0A);
      goto(480); bus.switchRaw[1] = 1'b0;

      goto(490);
      done = 1'b1;
   end

endmodule

// File: doc/io_frontend.md
IO_FRONTEND -- requirements
Module: io_frontend

Interface
REQ-001 The block SHALL have parameter NUM_SWITCHES, default 3, number of raw switch channels (minimum 3).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable synchronised samples needed to accept a level change (minimum 1).
REQ-003 The block SHALL have parameter REGISTER_WIDTH, default 8, which sets the outputValue and register1Value width.
REQ-004 The block SHALL have parameter PC_WIDTH, default 4, the pc width, with PC_WIDTH <= REGISTER_WIDTH.
REQ-005 The block SHALL have port clock  input  1  the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port isReset  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port switchRaw  input  NUM_SWITCHES  asynchronous raw switches: bit0 run/halt, bit1 step, bit2 display select, higher bits user.
REQ-008 The block SHALL have port pc  input  PC_WIDTH  the CPU program counter.
REQ-009 The block SHALL have port register1Value  input  REGISTER_WIDTH  the CPU register 1 value.
REQ-010 The block SHALL have port switchLevel  output  NUM_SWITCHES  the debounced level for each channel.
REQ-011 The block SHALL have port switchPressed  output  NUM_SWITCHES  a one-cycle pulse on each debounced 0->1 transition.
REQ-012 The block SHALL have port cpuEnable  output  1  the CPU clock-enable.
REQ-013 The block SHALL have port displayMode  output  2  the current display selection.
REQ-014 The block SHALL have port outputValue  output  REGISTER_WIDTH  the registered display value.

Function
REQ-015 Each channel SHALL pass through a 2-flop synchroniser before debounce.
REQ-016 Per channel, a counter SHALL increment while the synchronised value differs from switchLevel and SHALL clear whenever the two are equal.
REQ-017 When the counter reaches DEBOUNCE_CYCLES, switchLevel SHALL take the synchronised value and the counter SHALL clear.
REQ-018 Total latency from a clean raw edge to the switchLevel change SHALL be 2 + DEBOUNCE_CYCLES cycles; a glitch shorter than DEBOUNCE_CYCLES synchronised samples SHALL produce no change.
REQ-019 switchPressed[i] SHALL be high for exactly the one cycle in which switchLevel[i] rises; 1->0 transitions SHALL produce no pulse.
REQ-020 The control FSM SHALL have states HALT, RUN and STEP, with cpuEnable = 1 in RUN and STEP and 0 in HALT.
REQ-021 From HALT, switchPressed[0] SHALL go to RUN; otherwise switchPressed[1] SHALL go to STEP; if both pulse in the same cycle, RUN SHALL win.
REQ-022 STEP SHALL last exactly one cycle and then return to HALT unconditionally; presses arriving during STEP SHALL be ignored.
REQ-023 From RUN, switchPressed[0] SHALL go to HALT, and switchPressed[1] SHALL be ignored.
REQ-024 A cycle counter of REGISTER_WIDTH-1 bits SHALL increment on every cycle with cpuEnable = 1 and SHALL wrap from all-ones to 0.
REQ-025 displayMode SHALL advance 0->1->2->0 on switchPressed[2]; value 3 SHALL be unreachable and, if ever present, SHALL go to 0 on the next press.
REQ-026 outputValue SHALL be registered with one cycle of latency and selected by displayMode as follows: mode 0 = pc zero-extended to REGISTER_WIDTH; mode 1 = register1Value; mode 2 = {state==HALT, cycle counter}; mode 3 = 0.
REQ-027 outputValue SHALL reflect the displayMode value already updated in the cycle of a switchPressed[2] pulse, starting one cycle after that pulse.

Reset
REQ-028 While isReset is high at a clock edge, all of the following SHALL be cleared: synchronisers, debounce counters, switchLevel, switchPressed, cycle counter, displayMode and outputValue, and the FSM SHALL enter HALT, so cpuEnable = 0.
REQ-029 Reset asserted mid-debounce or during STEP or RUN SHALL abort the activity with no residual pulse after release.
REQ-030 A switch held high through reset SHALL emit its press pulse 2 + DEBOUNCE_CYCLES cycles after release.

Structure
REQ-031 Package cpu_io_pkg SHALL hold the FSM state enum (HALT, RUN, STEP) and the display-mode enum (DISP_PC, DISP_REG1, DISP_CYCLES).
REQ-032 The synchroniser, debounce counter and rise detector SHALL form sub-module switch_debouncer, instantiated NUM_SWITCHES times by a generate loop; the FSM, counter and display mux SHALL stay in io_frontend.

Verification (DEBOUNCE_CYCLES=4, REGISTER_WIDTH=8, PC_WIDTH=4)
REQ-033 Scenario: raw bit0 rises at cycle 10 and is held -> switchLevel[0] rises at cycle 16, switchPressed[0] pulses at cycle 16 only, cpuEnable = 1 from cycle 17.
REQ-034 Scenario: a 3-cycle pulse on bit1 -> no switchLevel change, no press, and the FSM stays in HALT.
REQ-035 Scenario: in HALT, a clean press on bit1 -> cpuEnable high for exactly 1 cycle and the cycle counter goes 0->1; then, with displayMode=2, outputValue = 8'h81.
REQ-036 Scenario: bits 0 and 1 pressed simultaneously from HALT -> RUN, and cpuEnable stays high.
REQ-037 Scenario: RUN for 130 cycles, then halt, with displayMode=2 -> the counter wraps through 127 to 0 and outputValue = {1, 7'd2} (counter = 130 mod 128 = 2).
REQ-038 Scenario: pc = 4'hA, three presses on bit2 -> outputValue shows 8'h0A, then register1Value, then cycles, then 8'h0A again, each one cycle after its press; isReset asserted in RUN -> cpuEnable = 0 and outputValue = 0 next cycle.
